fwd_scoreboard: RTL and testbench

//  Parametrised forwarding/stall unit for the D-stage read ports of the 5-stage MIPS pipeline.

---
 rtl/fwd_scoreboard.sv | 105 ++++++++++
 tb/tb_fwd_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// D-stage forwarding/stall unit with a shadow pipeline of destination records.
// Optional stall counters when FWD_STALL_CNT_EN is defined.
module fwd_scoreboard #(
  parameter int NPORT  = 2,
  parameter int NSTAGE = 3,
  parameter int TW     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [4:0]            d_a3,
  input  logic [TW-1:0]         d_tnew,
  input  logic [5*NPORT-1:0]    rd_addr,
  input  logic [TW*NPORT-1:0]   rd_tuse,
  input  logic [32*NPORT-1:0]   rd_data,
  input  logic [32*NSTAGE-1:0]  src_data,
  input  logic                  md_busy,
  input  logic                  d_is_md,
  output logic [32*NPORT-1:0]   fwd_data,
  output logic [NPORT-1:0]      fwd_pend,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           stall_md,
`endif
  output logic                  stall
);

  typedef struct packed {
    logic          v;
    logic [4:0]    a3;
    logic [TW-1:0] tnew;
  } rec_t;

  rec_t rec [NSTAGE];

  logic          hit      [NPORT];
  logic [TW-1:0] hit_tnew [NPORT];
  logic [31:0]   hit_src  [NPORT];
  logic [NPORT-1:0] port_stall;
  logic          md_stall;

  // Records always shift; E..W never freeze, a D stall only injects a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSTAGE; k++) rec[k] <= '0;
    end else begin
      rec[0].v    <= d_valid && (d_a3 != 5'd0) && !stall;
      rec[0].a3   <= d_a3;
      rec[0].tnew <= d_tnew;
      for (int k = 1; k < NSTAGE; k++) begin
        rec[k].v    <= rec[k-1].v;
        rec[k].a3   <= rec[k-1].a3;
        rec[k].tnew <= (rec[k-1].tnew == '0) ? '0
                     : rec[k-1].tnew - TW'(1);
      end
    end
  end

  // Scan oldest to youngest so the youngest match is the last write.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      hit[p]      = 1'b0;
      hit_tnew[p] = '0;
      hit_src[p]  = '0;
      for (int k = NSTAGE-1; k >= 0; k--) begin
        if (rec[k].v && rec[k].a3 == rd_addr[5*p +: 5]
            && rd_addr[5*p +: 5] != 5'd0) begin
          hit[p]      = 1'b1;
          hit_tnew[p] = rec[k].tnew;
          hit_src[p]  = src_data[32*k +: 32];
        end
      end
    end
  end

  always_comb begin
    fwd_data   = '0;
    fwd_pend   = '0;
    port_stall = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (hit[p] && hit_tnew[p] == '0)
        fwd_data[32*p +: 32] = hit_src[p];
      else
        fwd_data[32*p +: 32] = rd_data[32*p +: 32];
      fwd_pend[p]   = hit[p] && hit_tnew[p] != '0;
      port_stall[p] = hit[p] && hit_tnew[p] > rd_tuse[TW*p +: TW];
    end
  end

  assign md_stall = d_is_md & md_busy;
  assign stall    = (|port_stall) | md_stall;

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      stall_md  <= '0;
    end else begin
      if (stall)    stall_cnt <= stall_cnt + 32'd1;
      if (md_stall) stall_md  <= stall_md + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard.
// Counter checks are enabled with FWD_STALL_CNT_EN.
module tb_fwd_scoreboard;

  logic         clk = 1'b0;
  logic         reset;
  logic         d_valid;
  logic [4:0]   d_a3;
  logic [1:0]   d_tnew;
  logic [9:0]   rd_addr;
  logic [3:0]   rd_tuse;
  logic [63:0]  rd_data;
  logic [95:0]  src_data;
  logic         md_busy;
  logic         d_is_md;
  logic [63:0]  fwd_data;
  logic [1:0]   fwd_pend;
  logic         stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  stall_md;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] RD0 = 32'hDDDD_0000;
  localparam logic [31:0] RD1 = 32'hDDDD_0001;
  localparam logic [31:0] S0  = 32'h5C5C_0000;
  localparam logic [31:0] S1  = 32'h5C5C_0001;
  localparam logic [31:0] S2  = 32'h5C5C_0002;

  fwd_scoreboard #(.NPORT(2), .NSTAGE(3), .TW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_a3     (d_a3),
    .d_tnew   (d_tnew),
    .rd_addr  (rd_addr),
    .rd_tuse  (rd_tuse),
    .rd_data  (rd_data),
    .src_data (src_data),
    .md_busy  (md_busy),
    .d_is_md  (d_is_md),
    .fwd_data (fwd_data),
    .fwd_pend (fwd_pend),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
    .stall_md (stall_md),
`endif
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    d_valid = 1'b0;
    rd_addr = {5'd5, 5'd4};
    rd_tuse = '0;
    repeat (3) tick();
  endtask

  initial begin
    reset    = 1'b1;
    d_valid  = 1'b0;
    d_a3     = '0;
    d_tnew   = '0;
    rd_addr  = '0;
    rd_tuse  = '0;
    rd_data  = {RD1, RD0};
    src_data = {S2, S1, S0};
    md_busy  = 1'b0;
    d_is_md  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    rd_addr = {5'd5, 5'd4};
    #1;
    check("rst_fwd0", fwd_data[31:0], RD0);
    check("rst_fwd1", fwd_data[63:32], RD1);
    check("rst_pend", 32'(fwd_pend), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // tnew=0 producer, follow it down the pipe
    d_valid = 1'b1; d_a3 = 5'd8; d_tnew = 2'd0;
    tick();
    d_valid = 1'b0;
    rd_addr = {5'd5, 5'd8};
    #1;
    check("jal_fwd_e", fwd_data[31:0], S0);
    check("jal_pend", 32'(fwd_pend), 32'd0);
    check("jal_stall", 32'(stall), 32'd0);
    tick();
    check("jal_fwd_m", fwd_data[31:0], S1);
    tick();
    check("jal_fwd_w", fwd_data[31:0], S2);
    tick();
    check("jal_dropped", fwd_data[31:0], RD0);
    flush();

    // lw -> beq, tuse=0; issue during stall becomes a bubble
    d_valid = 1'b1; d_a3 = 5'd9; d_tnew = 2'd2;
    tick();
    d_a3 = 5'd14; d_tnew = 2'd0;
    rd_addr = {5'd9, 5'd14};
    #1;
    check("lw_beq_stall1", 32'(stall), 32'd1);
    check("lw_beq_pend1", 32'(fwd_pend), 32'd2);
    tick();
    d_valid = 1'b0;
    #1;
    check("lw_beq_stall2", 32'(stall), 32'd1);
    check("stall_bubble", fwd_data[31:0], RD0);
    tick();
    check("lw_beq_go", 32'(stall), 32'd0);
    check("lw_beq_fwd", fwd_data[63:32], S2);
    check("lw_beq_pend0", 32'(fwd_pend), 32'd0);
    flush();

    // lw -> add, tuse=1
    d_valid = 1'b1; d_a3 = 5'd9; d_tnew = 2'd2;
    tick();
    d_valid = 1'b0;
    rd_addr = {5'd9, 5'd4};
    rd_tuse = {2'd1, 2'd0};
    #1;
    check("lw_add_stall", 32'(stall), 32'd1);
    tick();
    check("lw_add_go", 32'(stall), 32'd0);
    check("lw_add_pend", 32'(fwd_pend), 32'd2);
    check("lw_add_rd", fwd_data[63:32], RD1);
    tick();
    check("lw_add_pend0", 32'(fwd_pend), 32'd0);
    check("lw_add_fwd", fwd_data[63:32], S2);
    flush();

    // youngest producer wins
    d_valid = 1'b1; d_a3 = 5'd10; d_tnew = 2'd0;
    tick();
    tick();
    d_valid = 1'b0;
    rd_addr = {5'd0, 5'd10};
    #1;
    check("young_fwd", fwd_data[31:0], S0);
    check("zero_addr_fwd1", fwd_data[63:32], RD1);
    check("young_stall", 32'(stall), 32'd0);

    // $0 is never recorded
    d_valid = 1'b1; d_a3 = 5'd0; d_tnew = 2'd3;
    rd_addr = {5'd5, 5'd4};
    tick();
    d_valid = 1'b0;
    rd_addr = {5'd0, 5'd0};
    #1;
    check("zero_rec_stall", 32'(stall), 32'd0);
    check("zero_rec_fwd", fwd_data[31:0], RD0);
    flush();

    // issue not visible same cycle, visible next
    d_valid = 1'b1; d_a3 = 5'd12; d_tnew = 2'd3;
    rd_addr = {5'd5, 5'd12};
    #1;
    check("same_cyc_stall", 32'(stall), 32'd0);
    check("same_cyc_fwd", fwd_data[31:0], RD0);
    tick();
    d_valid = 1'b0;
    #1;
    check("next_cyc_stall", 32'(stall), 32'd1);
    check("next_cyc_pend", 32'(fwd_pend), 32'd1);
    flush();

    // reset forgets in-flight hazards
    d_valid = 1'b1; d_a3 = 5'd20; d_tnew = 2'd3;
    tick();
    d_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_addr = {5'd5, 5'd20};
    #1;
    check("rst_clr_stall", 32'(stall), 32'd0);
    check("rst_clr_pend", 32'(fwd_pend), 32'd0);

    // mult/div stall across a mid-sequence reset
    rd_addr = {5'd5, 5'd4};
    md_busy = 1'b1; d_is_md = 1'b1;
    #1;
    check("md_c0", 32'(stall), 32'd1);
    tick();
    check("md_c1", 32'(stall), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("md_c2_rst", 32'(stall), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("md_c3", 32'(stall), 32'd1);
`ifdef FWD_STALL_CNT_EN
    check("cnt_after_rst", stall_cnt, 32'd0);
    check("md_after_rst", stall_md, 32'd0);
`endif
    tick();
    check("md_c4", 32'(stall), 32'd1);
`ifdef FWD_STALL_CNT_EN
    check("cnt_one", stall_cnt, 32'd1);
    check("md_one", stall_md, 32'd1);
`endif
    d_is_md = 1'b0;
    #1;
    check("md_busy_only", 32'(stall), 32'd0);
    md_busy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
